// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core. One shared datapath is stepped through
// FETCH/DECODE/EXEC/MEM/WB, with on-chip instruction and data memories.
module mips_multicycle #(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter int unsigned DMEM_DEPTH = 128
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic [4:0]                    dbg_reg_addr,
    output logic [31:0]                   dbg_reg_data,
    output logic [31:0]                   pc,
    output logic [2:0]                    state,
    output logic                          retire,
    output logic [31:0]                   instr_count,
    output logic                          halted
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [5:0] FnAdd = 6'd32;
    localparam logic [5:0] FnSub = 6'd34;
    localparam logic [5:0] FnAnd = 6'd36;
    localparam logic [5:0] FnOr  = 6'd37;
    localparam logic [5:0] FnNor = 6'd39;
    localparam logic [5:0] FnSlt = 6'd42;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       imm_q;
    logic [31:0]       alu_q;
    logic [31:0]       mdr_q;
    logic [31:0]       count_q;
    logic [31:0][31:0] regs_q;
    logic [31:0]       imem_q [IMEM_DEPTH];
    // Holds (data ^ word index) so that an all-zero power-up reads back as word i = i.
    logic [31:0]       dmem_q [DMEM_DEPTH];

    logic ir_we, ab_we, alu_we, br_taken, jump, dmem_we, mdr_we, rf_we;

    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [4:0]     rs, rt, rd;
    logic [31:0]    simm;
    logic [31:0]    alu_res;
    logic [4:0]     rf_waddr;
    logic [31:0]    rf_wdata;
    logic [DAW-1:0] daddr;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign daddr  = alu_q[2 +: DAW];

    assign rf_waddr = (opcode == OpRtype) ? rd : rt;
    assign rf_wdata = (opcode == OpLw) ? mdr_q : alu_q;

    assign pc           = pc_q;
    assign state        = state_q;
    assign instr_count  = count_q;
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : regs_q[dbg_reg_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: sequence length depends on the opcode latched in IR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = (opcode == OpHalt) ? StHalt : StExec;
            StExec: begin
                if (opcode == OpRtype || opcode == OpAddi) begin
                    state_d = StWb;
                end else if (opcode == OpLw || opcode == OpSw) begin
                    state_d = StMem;
                end else begin
                    state_d = StFetch;
                end
            end
            StMem:    state_d = (opcode == OpLw) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Per-state datapath controls, retire pulse and halted flag.
    always_comb begin
        ir_we    = 1'b0;
        ab_we    = 1'b0;
        alu_we   = 1'b0;
        br_taken = 1'b0;
        jump     = 1'b0;
        dmem_we  = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        retire   = 1'b0;
        halted   = (state_q == StHalt);
        unique case (state_q)
            StFetch:  ir_we = 1'b1;
            StDecode: ab_we = 1'b1;
            StExec: begin
                alu_we   = 1'b1;
                jump     = (opcode == OpJ);
                br_taken = ((opcode == OpBeq) && (a_q == b_q)) ||
                           ((opcode == OpBne) && (a_q != b_q));
                // Branches, jumps and unknown opcodes finish here.
                retire   = !(opcode inside {OpRtype, OpAddi, OpLw, OpSw});
            end
            StMem: begin
                dmem_we = (opcode == OpSw);
                mdr_we  = (opcode == OpLw);
                retire  = (opcode == OpSw);
            end
            StWb: begin
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU: R-type by funct, everything else is A + simm (addi and effective address).
    always_comb begin
        alu_res = a_q + imm_q;
        if (opcode == OpRtype) begin
            case (funct)
                FnAdd:   alu_res = a_q + b_q;
                FnSub:   alu_res = a_q - b_q;
                FnAnd:   alu_res = a_q & b_q;
                FnOr:    alu_res = a_q | b_q;
                FnNor:   alu_res = ~(a_q | b_q);
                FnSlt:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                default: alu_res = 32'd0;
            endcase
        end
    end

    // Datapath registers: PC, IR, operand latches, ALU output and memory data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q  <= 32'd0;
            ir_q  <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            imm_q <= 32'd0;
            alu_q <= 32'd0;
            mdr_q <= 32'd0;
        end else begin
            if (ir_we) begin
                ir_q <= imem_q[pc_q[2 +: IAW]];
                pc_q <= pc_q + 32'd4;
            end
            if (ab_we) begin
                a_q   <= regs_q[rs];
                b_q   <= regs_q[rt];
                imm_q <= simm;
            end
            if (alu_we) begin
                alu_q <= alu_res;
            end
            // PC already holds the incremented value here.
            if (br_taken) begin
                pc_q <= pc_q + (imm_q << 2);
            end else if (jump) begin
                pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            if (mdr_we) begin
                mdr_q <= dmem_q[daddr] ^ 32'(daddr);
            end
        end
    end

    // Register file: r8..r15 preload to 0..7 on reset; r0 never written.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= (i >= 8 && i <= 15) ? 32'(i - 8) : 32'd0;
            end
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Retired-instruction counter, bumped in the retire cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 32'd0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Instruction memory load port; unaffected by reset or FSM state.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_addr] <= imem_wdata;
        end
    end

    // Data memory write; contents persist across reset, and a reset aborts a pending store.
    always_ff @(posedge clk) begin
        if (reset_n && dmem_we) begin
            dmem_q[daddr] <= b_q ^ 32'(daddr);
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: directed scenarios, a vector table
// and random forward-only programs checked against an ISA-level interpreter.
module tb_mips_multicycle;

    localparam int unsigned IMEM_DEPTH = 32;
    localparam int unsigned DMEM_DEPTH = 128;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [4:0]  imem_addr = 5'd0;
    logic [31:0] imem_wdata = 32'd0;
    logic [4:0]  dbg_reg_addr = 5'd0;
    logic [31:0] dbg_reg_data;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] instr_count;
    logic        halted;

    always #5 clk = ~clk;

    mips_multicycle #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .DMEM_DEPTH(DMEM_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_data(dbg_reg_data),
        .pc(pc),
        .state(state),
        .retire(retire),
        .instr_count(instr_count),
        .halted(halted)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] prog   [32];
    logic [31:0] m_imem [32];
    logic [31:0] m_dmem [128];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    int          m_cycles;

    int dut_cycles;
    int dut_retires;
    int first_retire;

    typedef struct {
        string       name;
        logic [31:0] i0;
        logic [31:0] i1;
        int          ridx;
        logic [31:0] exp;
        int          cycles;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'd2, 26'(target)};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] i0, input logic [31:0] i1,
                                input int r, input logic [31:0] e, input int c);
        vec_t v;
        v.name = n; v.i0 = i0; v.i1 = i1; v.ridx = r; v.exp = e; v.cycles = c;
        return v;
    endfunction

    // ISA interpreter; cycles = per-instruction costs plus 3 to reach HALT.
    task automatic model_run();
        logic [31:0] ir, a, b, simm, ea, res;
        int unsigned idx;
        bit done;
        int steps;
        done = 0;
        steps = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = (i >= 8 && i <= 15) ? 32'(i - 8) : 32'd0;
        m_pc = 0; m_count = 0; m_cycles = 0;
        while (!done && steps < 1000) begin
            steps++;
            ir = m_imem[(m_pc >> 2) % 32];
            m_pc = m_pc + 4;
            a = m_regs[ir[25:21]];
            b = m_regs[ir[20:16]];
            simm = {{16{ir[15]}}, ir[15:0]};
            ea = a + simm;
            idx = (ea >> 2) % DMEM_DEPTH;
            case (ir[31:26])
                6'h3F: begin done = 1; m_cycles += 3; end
                6'h00: begin
                    case (ir[5:0])
                        6'd32:   res = a + b;
                        6'd34:   res = a - b;
                        6'd36:   res = a & b;
                        6'd37:   res = a | b;
                        6'd39:   res = ~(a | b);
                        6'd42:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: res = 32'd0;
                    endcase
                    if (ir[15:11] != 0) m_regs[ir[15:11]] = res;
                    m_cycles += 4;
                end
                6'h08: begin
                    if (ir[20:16] != 0) m_regs[ir[20:16]] = ea;
                    m_cycles += 4;
                end
                6'h23: begin
                    if (ir[20:16] != 0) m_regs[ir[20:16]] = m_dmem[idx];
                    m_cycles += 5;
                end
                6'h2B: begin m_dmem[idx] = b; m_cycles += 4; end
                6'h04: begin if (a == b) m_pc = m_pc + (simm * 4); m_cycles += 3; end
                6'h05: begin if (a != b) m_pc = m_pc + (simm * 4); m_cycles += 3; end
                6'h02: begin m_pc = {m_pc[31:28], ir[25:0], 2'b00}; m_cycles += 3; end
                default: m_cycles += 3;
            endcase
            if (!done) m_count = m_count + 1;
        end
    endtask

    // Writes all of imem while holding reset; leaves reset asserted, at a negedge.
    task automatic load_prog();
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            imem_we = 1'b1;
            imem_addr = 5'(i);
            imem_wdata = prog[i];
            @(posedge clk); @(negedge clk);
        end
        imem_we = 1'b0;
        for (int i = 0; i < 32; i++) m_imem[i] = prog[i];
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_reg_addr = 5'(r);
        #1;
        v = dbg_reg_data;
    endtask

    // Releases reset; cycle numbering starts at 1 in the first FETCH.
    task automatic run_to_halt(input int start_c, input int budget);
        int c;
        c = start_c;
        dut_cycles = -1;
        dut_retires = 0;
        first_retire = 0;
        reset_n = 1'b1;
        while (c <= budget) begin
            if (halted) begin
                dut_cycles = c;
                break;
            end
            if (retire) begin
                dut_retires++;
                if (first_retire == 0) first_retire = c;
            end
            @(posedge clk); @(negedge clk);
            c++;
        end
        check("halt reached", 32'(halted), 32'd1);
    endtask

    task automatic compare_model(input string name);
        logic [31:0] v;
        logic [31:0] pc_at_halt;
        model_run();
        pc_at_halt = pc;
        check({name, " cycles"}, 32'(dut_cycles), 32'(m_cycles));
        check({name, " instr_count"}, instr_count, m_count);
        check({name, " retires"}, 32'(dut_retires), m_count);
        check({name, " pc"}, pc, m_pc);
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check($sformatf("%s r%0d", name, r), v, m_regs[r]);
        end
        @(negedge clk);
        check({name, " halt holds pc"}, pc, pc_at_halt);
        check({name, " halt holds state"}, 32'(state), 32'd5);
        check({name, " halt holds count"}, instr_count, m_count);
    endtask

    function automatic logic [31:0] rand_instr(input int i);
        int k, rs, rt, rd;
        int fns [8];
        int bad [5];
        fns = '{32, 34, 36, 37, 39, 42, 0, 43};
        bad = '{1, 12, 15, 32, 62};
        k = $urandom_range(0, 9);
        rs = $urandom_range(0, 17);
        rt = $urandom_range(0, 17);
        rd = $urandom_range(0, 17);
        case (k)
            0, 1: return enc_r(rs, rt, rd, fns[$urandom_range(0, 7)]);
            2:    return enc_i(8, rs, rt, $urandom_range(0, 65535));
            3:    return enc_i(35, rs, rt, $urandom_range(0, 65535));
            4:    return enc_i(43, rs, rt, $urandom_range(0, 65535));
            5:    return enc_i(4, rs, rt, $urandom_range(0, 2));
            6:    return enc_i(5, rs, rt, $urandom_range(0, 2));
            7:    return enc_j(i + 1 + $urandom_range(0, 3));
            8:    return {6'(bad[$urandom_range(0, 4)]), 26'($urandom)};
            default: return enc_i(8, rs, rt, $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        int c;

        for (int i = 0; i < 128; i++) m_dmem[i] = 32'(i);

        vecs[0]  = mk("add",      enc_r(14, 15, 16, 32), HALT, 16, 32'd13, 7);
        vecs[1]  = mk("sub",      enc_r(9, 15, 16, 34),  HALT, 16, 32'hFFFF_FFFA, 7);
        vecs[2]  = mk("and",      enc_r(14, 15, 16, 36), HALT, 16, 32'd6, 7);
        vecs[3]  = mk("or",       enc_r(12, 11, 16, 37), HALT, 16, 32'd7, 7);
        vecs[4]  = mk("nor",      enc_r(9, 10, 16, 39),  HALT, 16, 32'hFFFF_FFFC, 7);
        vecs[5]  = mk("slt0",     enc_r(15, 9, 15, 42),  HALT, 15, 32'd0, 7);
        vecs[6]  = mk("slt1",     enc_r(9, 15, 16, 42),  HALT, 16, 32'd1, 7);
        vecs[7]  = mk("slt neg",  enc_i(8, 0, 16, -3), enc_r(16, 9, 17, 42), 17, 32'd1, 11);
        vecs[8]  = mk("bad fn",   enc_r(14, 15, 15, 0),  HALT, 15, 32'd0, 7);
        vecs[9]  = mk("addi",     enc_i(8, 13, 17, -8),  HALT, 17, 32'hFFFF_FFFD, 7);
        vecs[10] = mk("lw",       enc_i(35, 9, 18, 20),  HALT, 18, 32'd5, 8);
        vecs[11] = mk("lw wrap",  enc_i(35, 8, 18, -4),  HALT, 18, 32'd127, 8);
        vecs[12] = mk("r0",       enc_i(8, 0, 0, 5),     HALT, 0, 32'd0, 7);
        vecs[13] = mk("unknown",  enc_i(15, 0, 9, 5),    HALT, 9, 32'd1, 6);
        vecs[14] = mk("sw lw",    enc_i(43, 0, 15, 8), enc_i(35, 0, 19, 8), 19, 32'd7, 12);

        @(negedge clk);

        // Reset state, then abort a store in MEM.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(43, 28, 9, 0);
        load_prog();
        check("reset pc", pc, 32'd0);
        check("reset state", 32'(state), 32'd0);
        check("reset retire", 32'(retire), 32'd0);
        check("reset count", instr_count, 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        for (int r = 0; r < 32; r++) begin
            read_reg(r, v);
            check($sformatf("reset r%0d", r), v, (r >= 8 && r <= 15) ? 32'(r - 8) : 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        c = 0;
        while (c < 10 && state != 3'd3) begin
            @(posedge clk); @(negedge clk);
            c++;
        end
        check("sw reaches MEM", 32'(state), 32'd3);
        reset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort pc", pc, 32'd0);
        check("abort state", 32'(state), 32'd0);
        for (int r = 8; r < 16; r++) begin
            read_reg(r, v);
            check($sformatf("abort r%0d", r), v, 32'(r - 8));
        end
        @(negedge clk);
        prog[0] = enc_i(35, 0, 16, 0);
        load_prog();
        run_to_halt(1, 100);
        compare_model("abort lw");
        read_reg(16, v);
        check("aborted sw word0", v, 32'd0);
        @(negedge clk);

        // Loop program.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = 32'h0000_4820; prog[1] = 32'h8f8a_0004; prog[2] = 32'h8f8b_0008;
        prog[3] = 32'h012a_4820; prog[4] = 32'h216b_ffff; prog[5] = 32'h1560_fffd;
        prog[6] = 32'haf89_0000; prog[7] = 32'h8f8c_0000; prog[8] = 32'hfc00_0000;
        load_prog();
        run_to_halt(1, 200);
        compare_model("loop");
        read_reg(9, v);  check("loop r9", v, 32'd2);
        read_reg(12, v); check("loop r12", v, 32'd2);
        check("loop count", instr_count, 32'd11);
        check("loop pc", pc, 32'd36);
        @(negedge clk);

        // addi to r0: single retire in cycle 4.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(8, 0, 0, 5);
        load_prog();
        run_to_halt(1, 100);
        check("r0 retire cycle", 32'(first_retire), 32'd4);
        check("r0 retire count", 32'(dut_retires), 32'd1);
        compare_model("r0");

        // beq taken skips addi; bne not taken does not.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(4, 8, 8, 1);
        prog[1] = enc_i(8, 9, 9, 9);
        load_prog();
        run_to_halt(1, 100);
        check("beq retire cycle", 32'(first_retire), 32'd3);
        check("beq cycles", 32'(dut_cycles), 32'd6);
        compare_model("beq");
        read_reg(9, v); check("beq r9", v, 32'd1);
        @(negedge clk);
        prog[0] = enc_i(5, 8, 8, 1);
        load_prog();
        run_to_halt(1, 100);
        check("bne retire cycle", 32'(first_retire), 32'd3);
        check("bne cycles", 32'(dut_cycles), 32'd10);
        compare_model("bne");
        read_reg(9, v); check("bne r9", v, 32'd10);
        @(negedge clk);

        // Signed slt.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(8, 0, 10, -1);
        prog[1] = enc_r(10, 9, 11, 42);
        load_prog();
        run_to_halt(1, 100);
        compare_model("slt");
        read_reg(11, v); check("slt r11", v, 32'd1);
        @(negedge clk);

        // Jump to word 32 wraps to imem[0].
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(8, 17, 17, 1);
        prog[1] = enc_i(4, 17, 10, 1);
        prog[2] = enc_j(32);
        load_prog();
        run_to_halt(1, 100);
        compare_model("wrap");
        read_reg(17, v); check("wrap r17", v, 32'd2);
        check("wrap pc", pc, 32'd144);
        @(negedge clk);

        // imem write to the word being fetched: FETCH sees the old word.
        for (int i = 0; i < 32; i++) prog[i] = HALT;
        prog[0] = enc_i(8, 0, 16, 7);
        prog[1] = enc_j(0);
        load_prog();
        reset_n = 1'b1;
        imem_we = 1'b1; imem_addr = 5'd0; imem_wdata = HALT;
        @(posedge clk); @(negedge clk);
        imem_we = 1'b0;
        run_to_halt(2, 100);
        check("imem race cycles", 32'(dut_cycles), 32'd10);
        check("imem race count", instr_count, 32'd2);
        check("imem race pc", pc, 32'd4);
        read_reg(16, v); check("imem race r16", v, 32'd7);
        @(negedge clk);

        // Vector table.
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < 32; i++) prog[i] = HALT;
            prog[0] = vecs[t].i0;
            prog[1] = vecs[t].i1;
            load_prog();
            run_to_halt(1, 100);
            check({vecs[t].name, " table cycles"}, 32'(dut_cycles), 32'(vecs[t].cycles));
            compare_model(vecs[t].name);
            read_reg(vecs[t].ridx, v);
            check({vecs[t].name, " table reg"}, v, vecs[t].exp);
            @(negedge clk);
        end

        // Random forward-only programs.
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 32; i++) prog[i] = HALT;
            for (int i = 0; i < 12; i++) prog[i] = rand_instr(i);
            load_prog();
            run_to_halt(1, 200);
            compare_model($sformatf("rand%0d", p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
